serial_parity_receiver: RTL and testbench

- Receive end of the team's XOR-based serial parity link.
- Accepts a bit-serial frame: start bit, DATA_WIDTH data bits sent LSB first, one parity bit, one stop bit.
- Reassembles the data word, recomputes parity with a running XOR and compares it against the received parity bit; flags parity and framing errors.
- Sits between the serial line sampler and the word-level consumer.

---
 rtl/serial_parity_receiver.sv | 141 ++++++++++++++
 tb/tb_serial_parity_receiver.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_parity_receiver.sv
// Receive end of the XOR serial parity link: start bit, DATA_WIDTH data bits LSB first, parity, stop.
// Define SERIAL_PARITY_ERR_COUNT_EN to build the saturating parity-error counter behind err_count.
module serial_parity_receiver #(
    parameter int DATA_WIDTH = 8,
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  bit_valid,
    input  logic                  bit_in,
    input  logic                  flush,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic [7:0]            err_count
);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    acc_q, acc_d;
    logic                    parity_ok_q, parity_ok_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic                    busy_q, busy_d;
    logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;
    logic                    data_valid_q, data_valid_d;
    logic                    parity_err_q, parity_err_d;
    logic                    frame_err_q, frame_err_d;
`ifdef SERIAL_PARITY_ERR_COUNT_EN
    logic [7:0]              err_count_q, err_count_d;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        parity_ok_d  = parity_ok_q;
        shift_d      = shift_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
`ifdef SERIAL_PARITY_ERR_COUNT_EN
        err_count_d  = err_count_q;
`endif

        // flush takes priority and swallows any bit presented in the same cycle
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
            acc_d   = 1'b0;
        end else if (bit_valid) begin
            case (state_q)
                IDLE: begin
                    if (!bit_in) begin
                        state_d = DATA;
                        cnt_d   = '0;
                        acc_d   = 1'b0;
                    end
                end
                DATA: begin
                    shift_d                 = shift_q >> 1;
                    shift_d[DATA_WIDTH-1]   = bit_in;
                    acc_d                   = acc_q ^ bit_in;
                    cnt_d                   = cnt_q + 1'b1;
                    if (cnt_q == LAST_BIT) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    parity_ok_d = ((acc_q ^ bit_in ^ ODD_PARITY) == 1'b0);
                    state_d     = STOP;
                end
                STOP: begin
                    data_valid_d = 1'b1;
                    data_out_d   = shift_q;
                    parity_err_d = ~parity_ok_q;
                    frame_err_d  = ~bit_in;
                    state_d      = IDLE;
`ifdef SERIAL_PARITY_ERR_COUNT_EN
                    if (!parity_ok_q && (err_count_q != 8'hFF)) begin
                        err_count_d = err_count_q + 8'd1;
                    end
`endif
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            acc_q        <= 1'b0;
            parity_ok_q  <= 1'b0;
            busy_q       <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef SERIAL_PARITY_ERR_COUNT_EN
            err_count_q  <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            parity_ok_q  <= parity_ok_d;
            busy_q       <= busy_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
`ifdef SERIAL_PARITY_ERR_COUNT_EN
            err_count_q  <= err_count_d;
`endif
        end
    end

    assign busy       = busy_q;
    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
`ifdef SERIAL_PARITY_ERR_COUNT_EN
    assign err_count  = err_count_q;
`else
    assign err_count  = 8'd0;
`endif

endmodule

// File: tb/tb_serial_parity_receiver.sv
// Scoreboard bench for serial_parity_receiver: an even-parity and an odd-parity instance side by side.
module tb_serial_parity_receiver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_e, bv_e, bi_e, fl_e;
    logic       busy_e, dv_e, pe_e, fe_e;
    logic [7:0] data_e, ec_e;
    logic       rst_o, bv_o, bi_o, fl_o;
    logic       busy_o, dv_o, pe_o, fe_o;
    logic [7:0] data_o, ec_o;

    serial_parity_receiver #(.DATA_WIDTH(8), .ODD_PARITY(1'b0)) u_even (
        .clk(clk), .rst(rst_e), .bit_valid(bv_e), .bit_in(bi_e), .flush(fl_e),
        .busy(busy_e), .data_out(data_e), .data_valid(dv_e),
        .parity_err(pe_e), .frame_err(fe_e), .err_count(ec_e)
    );

    serial_parity_receiver #(.DATA_WIDTH(8), .ODD_PARITY(1'b1)) u_odd (
        .clk(clk), .rst(rst_o), .bit_valid(bv_o), .bit_in(bi_o), .flush(fl_o),
        .busy(busy_o), .data_out(data_o), .data_valid(dv_o),
        .parity_err(pe_o), .frame_err(fe_o), .err_count(ec_o)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        logic [7:0] cnt;
    } exp_t;

    exp_t q_e[$];
    exp_t q_o[$];
    int   checks = 0;
    int   errors = 0;
    int   cnt_e  = 0;
    int   cnt_o  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every data_valid pulse must match the oldest expected frame
    always @(negedge clk) begin
        exp_t e;
        if (dv_e === 1'b1) begin
            if (q_e.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL even_unexpected_pulse: got pulse with data %0h expected none", data_e);
            end else begin
                e = q_e.pop_front();
                chk("even_data", {24'd0, data_e}, {24'd0, e.data});
                chk("even_perr", {31'd0, pe_e}, {31'd0, e.perr});
                chk("even_ferr", {31'd0, fe_e}, {31'd0, e.ferr});
                chk("even_errcnt", {24'd0, ec_e}, {24'd0, e.cnt});
                chk("even_busy_at_valid", {31'd0, busy_e}, 32'd0);
            end
        end
        if (dv_o === 1'b1) begin
            if (q_o.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL odd_unexpected_pulse: got pulse with data %0h expected none", data_o);
            end else begin
                e = q_o.pop_front();
                chk("odd_data", {24'd0, data_o}, {24'd0, e.data});
                chk("odd_perr", {31'd0, pe_o}, {31'd0, e.perr});
                chk("odd_ferr", {31'd0, fe_o}, {31'd0, e.ferr});
                chk("odd_errcnt", {24'd0, ec_o}, {24'd0, e.cnt});
                chk("odd_busy_at_valid", {31'd0, busy_o}, 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit odd, input logic v, input logic b, input logic f);
        if (odd) begin
            bv_o = v; bi_o = b; fl_o = f;
        end else begin
            bv_e = v; bi_e = b; fl_e = f;
        end
    endtask

    task automatic send_bit(input bit odd, input logic b, input int maxgap);
        int g;
        g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
        repeat (g) begin
            drive(odd, 1'b0, 1'b1, 1'b0);
            tick();
        end
        drive(odd, 1'b1, b, 1'b0);
        tick();
        drive(odd, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic send_frame(input bit odd, input logic [7:0] d, input logic par,
                              input logic stop, input logic perr_exp, input int maxgap);
        exp_t e;
        e.data = d;
        e.perr = perr_exp;
        e.ferr = ~stop;
        if (odd) begin
            if (perr_exp && cnt_o < 255) cnt_o++;
`ifdef SERIAL_PARITY_ERR_COUNT_EN
            e.cnt = 8'(cnt_o);
`else
            e.cnt = 8'd0;
`endif
            q_o.push_back(e);
        end else begin
            if (perr_exp && cnt_e < 255) cnt_e++;
`ifdef SERIAL_PARITY_ERR_COUNT_EN
            e.cnt = 8'(cnt_e);
`else
            e.cnt = 8'd0;
`endif
            q_e.push_back(e);
        end
        send_bit(odd, 1'b0, maxgap);
        for (int i = 0; i < 8; i++) send_bit(odd, d[i], maxgap);
        send_bit(odd, par, maxgap);
        send_bit(odd, stop, maxgap);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_e = 1'b1; rst_o = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (3) tick();
        chk("rst_busy", {31'd0, busy_e | busy_o}, 32'd0);
        chk("rst_data", {16'd0, data_e, data_o}, 32'd0);
        chk("rst_valid", {31'd0, dv_e | dv_o}, 32'd0);
        chk("rst_perr", {31'd0, pe_e | pe_o}, 32'd0);
        chk("rst_ferr", {31'd0, fe_e | fe_o}, 32'd0);
        chk("rst_errcnt", {16'd0, ec_e, ec_o}, 32'd0);
        rst_e = 1'b0; rst_o = 1'b0;
        tick();

        // 0xA5, good parity, good stop
        send_frame(1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, 0);
        chk("latency_valid", {31'd0, dv_e}, 32'd1);
        chk("busy_low_after", {31'd0, busy_e}, 32'd0);
        tick();
        chk("valid_one_cycle", {31'd0, dv_e}, 32'd0);

        // same frame, wrong parity bit
        send_frame(1'b0, 8'hA5, 1'b1, 1'b1, 1'b1, 0);
        tick();

        // bad stop bit must not start a new frame
        send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 0);
        tick();
        chk("stop0_idle", {31'd0, busy_e}, 32'd0);
        tick();
        chk("stop0_no_restart", {31'd0, busy_e}, 32'd0);

        // idle gaps between bits
        send_frame(1'b0, 8'h3C, 1'b0, 1'b1, 1'b0, 3);
        tick();

        // abort 0xFF after four data bits, flush coincident with a bit
        send_bit(1'b0, 1'b0, 0);
        for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b1, 0);
        chk("busy_mid_frame", {31'd0, busy_e}, 32'd1);
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        chk("flush_idle", {31'd0, busy_e}, 32'd0);
        chk("flush_hold_data", {24'd0, data_e}, 32'h3C);
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        chk("flush_drops_start", {31'd0, busy_e}, 32'd0);
        tick();
        send_frame(1'b0, 8'h3C, 1'b0, 1'b1, 1'b0, 0);
        tick();

        // odd parity instance
        send_frame(1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 0);
        tick();
        send_bit(1'b1, 1'b0, 0);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b1, 0);
        chk("odd_busy_mid", {31'd0, busy_o}, 32'd1);
        rst_o = 1'b1;
        tick();
        chk("midrst_busy", {31'd0, busy_o}, 32'd0);
        chk("midrst_data", {24'd0, data_o}, 32'd0);
        chk("midrst_flags", {29'd0, dv_o, pe_o, fe_o}, 32'd0);
        chk("midrst_errcnt", {24'd0, ec_o}, 32'd0);
        rst_o = 1'b0;
        cnt_o = 0;
        tick();

`ifdef SERIAL_PARITY_ERR_COUNT_EN
        for (int n = 0; n < 300; n++) send_frame(1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 0);
        tick();
        chk("errcnt_saturated", {24'd0, ec_o}, 32'd255);
`endif

        repeat (3) tick();
        chk("even_all_frames_seen", q_e.size(), 32'd0);
        chk("odd_all_frames_seen", q_o.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
